qam16_frame_ctrl: RTL

QAM16_FRAME_CTRL -- requirements
Module: qam16_frame_ctrl

---
 rtl/qam16_pkg.sv | 15 +
 rtl/qam16_nibble_split.sv | 40 ++++
 rtl/qam16_frame_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/qam16_pkg.sv
// Shared types and symbol codes for the QAM16 frame controller.
package qam16_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPreamble,
    StData,
    StDone
  } state_e;

  localparam logic [3:0] PreSymEven      = 4'b0000;
  localparam logic [3:0] PreSymOdd       = 4'b1111;
  localparam logic [3:0] PilotSymDefault = 4'b0000;

endpackage

// File: rtl/qam16_nibble_split.sv
// Byte-to-nibble splitter: the high nibble passes straight through on transfer,
// the low nibble is held until the next slot the controller grants.
module qam16_nibble_split (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       allow,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_nibble,
  output logic       out_low
);

  logic [3:0] low_q;
  logic       pend_q;
  logic       fire;
  logic       pop;

  assign in_ready   = allow && !pend_q;
  assign fire       = in_valid && in_ready;
  assign pop        = pend_q && out_ready;
  assign out_valid  = pend_q || fire;
  assign out_low    = pend_q;
  assign out_nibble = pend_q ? low_q : in_data[7:4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      low_q  <= '0;
      pend_q <= 1'b0;
    end else if (fire) begin
      low_q  <= in_data[3:0];
      pend_q <= 1'b1;
    end else if (pop) begin
      pend_q <= 1'b0;
    end
  end

endmodule

// File: rtl/qam16_frame_ctrl.sv
// Frame sequencer feeding a QAM16 mapper: preamble, then byte nibbles with
// periodic pilot symbols, then a one-cycle done pulse.
module qam16_frame_ctrl
  import qam16_pkg::*;
#(
  parameter int unsigned PRE_LEN      = 8,
  parameter int unsigned PILOT_PERIOD = 16,
  parameter logic [3:0]  PILOT_SYM    = PilotSymDefault
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] frame_len,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       valid_o,
  output logic [3:0] data_o,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] PreLast  = 8'(PRE_LEN - 1);
  localparam logic [7:0] PilotPer = 8'(PILOT_PERIOD);

  state_e     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] pre_cnt_q, pre_cnt_d;
  logic [7:0] pil_cnt_q, pil_cnt_d;
  logic       valid_q, valid_d;
  logic [3:0] data_q, data_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       accept;
  logic       in_data;
  logic       pilot_due;
  logic       split_allow;
  logic       split_out_ready;
  logic       split_valid;
  logic       split_low;
  logic [3:0] split_nibble;
  logic       last_low;

  assign accept          = (state_q == StIdle) && start && (frame_len != 8'd0);
  assign in_data         = (state_q == StData);
  assign pilot_due       = in_data && (pil_cnt_q == PilotPer);
  assign split_allow     = in_data && !pilot_due && (byte_cnt_q != len_q);
  assign split_out_ready = in_data && !pilot_due;
  assign last_low        = split_low && (byte_cnt_q == len_q);

  qam16_nibble_split u_split (
    .clk        (CLK),
    .rst_n      (RST),
    .allow      (split_allow),
    .in_valid   (byte_valid),
    .in_data    (byte_data),
    .in_ready   (byte_ready),
    .out_ready  (split_out_ready),
    .out_valid  (split_valid),
    .out_nibble (split_nibble),
    .out_low    (split_low)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= StIdle;
      len_q      <= '0;
      byte_cnt_q <= '0;
      pre_cnt_q  <= '0;
      pil_cnt_q  <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      pre_cnt_q  <= pre_cnt_d;
      pil_cnt_q  <= pil_cnt_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (accept) state_d = StPreamble;
      StPreamble: if (pre_cnt_q == PreLast) state_d = StData;
      StData:     if (!pilot_due && split_valid && last_low) state_d = StDone;
      StDone:     state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Symbol decided this cycle is registered and seen on data_o next cycle.
  always_comb begin
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    pre_cnt_d  = pre_cnt_q;
    pil_cnt_d  = pil_cnt_q;
    valid_d    = 1'b0;
    data_d     = data_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          len_d      = frame_len;
          byte_cnt_d = '0;
          pre_cnt_d  = '0;
          pil_cnt_d  = '0;
          busy_d     = 1'b1;
        end
      end
      StPreamble: begin
        busy_d    = 1'b1;
        valid_d   = 1'b1;
        data_d    = pre_cnt_q[0] ? PreSymOdd : PreSymEven;
        pre_cnt_d = pre_cnt_q + 8'd1;
      end
      StData: begin
        busy_d = 1'b1;
        if (pilot_due) begin
          valid_d   = 1'b1;
          data_d    = PILOT_SYM;
          pil_cnt_d = '0;
        end else if (split_valid) begin
          valid_d   = 1'b1;
          data_d    = split_nibble;
          pil_cnt_d = pil_cnt_q + 8'd1;
        end
        if (byte_valid && byte_ready) byte_cnt_d = byte_cnt_q + 8'd1;
      end
      StDone: begin
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
